// File: rtl/seq_shift_reg.sv
// WIDTH-bit datapath register with parallel load and multi-cycle shift/rotate,
// one bit position per enabled clock, reporting completion on busy/done.
module seq_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] OP_SHL = 3'b000;
  localparam logic [2:0] OP_SHR = 3'b001;
  localparam logic [2:0] OP_SAR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_SLI = 3'b101;
  localparam logic [2:0] OP_SRI = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;

  logic [WIDTH-1:0] step_q;
  logic             step_sout;

  // Single-bit step of the latched operation; the reserved op holds q and sout.
  always_comb begin
    step_q    = q_q;
    step_sout = sout_q;
    case (op_q)
      OP_SHL: begin
        step_q    = {q_q[WIDTH-2:0], 1'b0};
        step_sout = q_q[WIDTH-1];
      end
      OP_SHR: begin
        step_q    = {1'b0, q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_SAR: begin
        step_q    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_ROL: begin
        step_q    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        step_sout = q_q[WIDTH-1];
      end
      OP_ROR: begin
        step_q    = {q_q[0], q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      OP_SLI: begin
        step_q    = {q_q[WIDTH-2:0], sin};
        step_sout = q_q[WIDTH-1];
      end
      OP_SRI: begin
        step_q    = {sin, q_q[WIDTH-1:1]};
        step_sout = q_q[0];
      end
      default: begin
        step_q    = q_q;
        step_sout = sout_q;
      end
    endcase
  end

  // done defaults low every edge so the pulse clears even while en is low.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    op_d    = op_q;
    if (en) begin
      if (clr) begin
        q_d = '0;
        if (state_q == SHIFT) begin
          sout_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            if (load) begin
              q_d = d;
            end else if (start) begin
              if (amt != '0) begin
                op_d    = op;
                cnt_d   = amt;
                state_d = SHIFT;
              end else begin
                done_d = 1'b1;
              end
            end
          end
          SHIFT: begin
            q_d    = step_q;
            sout_d = step_sout;
            cnt_d  = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= OP_SHL;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = (state_q == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_seq_shift_reg.sv
// Directed-vector bench for seq_shift_reg (WIDTH=8, AMT_W=4).
module tb_seq_shift_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic       clr;
  logic       load;
  logic [7:0] d;
  logic       start;
  logic [2:0] op;
  logic [3:0] amt;
  logic       sin;
  logic [7:0] q;
  logic       sout;
  logic       busy;
  logic       done;

  int nvec;
  int nerr;

  seq_shift_reg #(.WIDTH(8), .AMT_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .clr  (clr),
    .load (load),
    .d    (d),
    .start(start),
    .op   (op),
    .amt  (amt),
    .sin  (sin),
    .q    (q),
    .sout (sout),
    .busy (busy),
    .done (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    d    = v;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] o, input logic [3:0] a);
    start = 1'b1;
    op    = o;
    amt   = a;
    cyc();
    start = 1'b0;
    op    = 3'b111;
    amt   = 4'hF;
  endtask

  task automatic test_reset();
    nvec++;
    if ({q, sout, busy, done} !== 11'h0) begin
      nerr++;
      $display("FAIL reset: q=%h sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
    end
  endtask

  task automatic test_rol_one();
    do_load(8'h81);
    do_start(3'b011, 4'd1);
    nvec++;
    if (busy !== 1'b1 || q !== 8'h81) begin
      nerr++;
      $display("FAIL rol1_e0: busy=%b q=%h, want busy=1 q=81", busy, q);
    end
    cyc();
    nvec++;
    if (q !== 8'h03 || sout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL rol1_e1: q=%h sout=%b done=%b busy=%b, want 03 1 1 0", q, sout, done, busy);
    end
    cyc();
    nvec++;
    if (done !== 1'b0) begin
      nerr++;
      $display("FAIL rol1_done_clear: done=%b, want 0", done);
    end
  endtask

  task automatic test_sar_shr();
    int nbusy;
    do_load(8'h90);
    do_start(3'b010, 4'd3);
    nbusy = busy ? 1 : 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (busy) nbusy++;
    end
    nvec++;
    if (q !== 8'hF2 || sout !== 1'b0 || done !== 1'b1 || nbusy != 3) begin
      nerr++;
      $display("FAIL sar3: q=%h sout=%b done=%b busy_cycles=%0d, want F2 0 1 3", q, sout, done, nbusy);
    end
    cyc();
    do_load(8'h90);
    do_start(3'b001, 4'd3);
    repeat (3) cyc();
    nvec++;
    if (q !== 8'h12 || sout !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL shr3: q=%h sout=%b done=%b, want 12 0 1", q, sout, done);
    end
    cyc();
  endtask

  task automatic test_pause();
    int ndone;
    ndone = 0;
    do_load(8'h0F);
    do_start(3'b000, 4'd4);
    nvec++;
    if (q !== 8'h0F || busy !== 1'b1) begin
      nerr++;
      $display("FAIL pause_e0: q=%h busy=%b, want 0F 1", q, busy);
    end
    cyc();
    nvec++;
    if (q !== 8'h1E) begin
      nerr++;
      $display("FAIL pause_e1: q=%h, want 1E", q);
    end
    cyc();
    nvec++;
    if (q !== 8'h3C) begin
      nerr++;
      $display("FAIL pause_e2: q=%h, want 3C", q);
    end
    en    = 1'b0;
    start = 1'b1;
    load  = 1'b1;
    d     = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (done) ndone++;
      nvec++;
      if (q !== 8'h3C || busy !== 1'b1 || sout !== 1'b0) begin
        nerr++;
        $display("FAIL pause_hold%0d: q=%h busy=%b sout=%b, want 3C 1 0", i, q, busy, sout);
      end
    end
    en    = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    cyc();
    if (done) ndone++;
    nvec++;
    if (q !== 8'h78) begin
      nerr++;
      $display("FAIL pause_e3: q=%h, want 78", q);
    end
    cyc();
    if (done) ndone++;
    nvec++;
    if (q !== 8'hF0 || busy !== 1'b0 || sout !== 1'b0) begin
      nerr++;
      $display("FAIL pause_e4: q=%h busy=%b sout=%b, want F0 0 0", q, busy, sout);
    end
    cyc();
    if (done) ndone++;
    nvec++;
    if (ndone != 1) begin
      nerr++;
      $display("FAIL pause_done_count: %0d pulses, want 1", ndone);
    end
  endtask

  task automatic test_amt_zero();
    do_load(8'h5A);
    do_start(3'b000, 4'd0);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b1 || q !== 8'h5A) begin
      nerr++;
      $display("FAIL amt0: busy=%b done=%b q=%h, want 0 1 5A", busy, done, q);
    end
    cyc();
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h5A) begin
      nerr++;
      $display("FAIL amt0_after: busy=%b done=%b q=%h, want 0 0 5A", busy, done, q);
    end
  endtask

  task automatic test_clr_abort();
    int ndone;
    ndone = 0;
    do_load(8'hA5);
    do_start(3'b000, 4'd5);
    cyc();
    cyc();
    nvec++;
    if (q !== 8'h94 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL clr_pre: q=%h busy=%b, want 94 1", q, busy);
    end
    clr   = 1'b1;
    start = 1'b1;
    load  = 1'b1;
    d     = 8'hFF;
    op    = 3'b011;
    amt   = 4'd2;
    cyc();
    clr   = 1'b0;
    start = 1'b0;
    load  = 1'b0;
    if (done) ndone++;
    nvec++;
    if (q !== 8'h00 || busy !== 1'b0 || sout !== 1'b0) begin
      nerr++;
      $display("FAIL clr_abort: q=%h busy=%b sout=%b, want 00 0 0", q, busy, sout);
    end
    repeat (6) begin
      cyc();
      if (done) ndone++;
    end
    nvec++;
    if (ndone != 0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL clr_no_done: %0d pulses busy=%b, want 0 0", ndone, busy);
    end
  endtask

  task automatic test_rst_mid_op();
    int ndone;
    ndone = 0;
    do_load(8'hA5);
    do_start(3'b000, 4'd3);
    cyc();
    cyc();
    nvec++;
    if (q !== 8'h94 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL rst_pre: q=%h busy=%b, want 94 1", q, busy);
    end
    rst = 1'b1;
    #1;
    nvec++;
    if ({q, sout, busy, done} !== 11'h0) begin
      nerr++;
      $display("FAIL rst_async: q=%h sout=%b busy=%b done=%b, want all 0", q, sout, busy, done);
    end
    rst = 1'b0;
    repeat (4) begin
      cyc();
      if (done || busy) ndone++;
    end
    nvec++;
    if (ndone != 0) begin
      nerr++;
      $display("FAIL rst_no_done: %0d cycles with done/busy, want 0", ndone);
    end
  endtask

  task automatic test_wide_amt();
    do_load(8'h81);
    do_start(3'b011, 4'd9);
    repeat (9) cyc();
    nvec++;
    if (q !== 8'h03 || done !== 1'b1) begin
      nerr++;
      $display("FAIL rol9_wrap: q=%h done=%b, want 03 1", q, done);
    end
    cyc();
    do_load(8'hFF);
    do_start(3'b000, 4'd9);
    repeat (9) cyc();
    nvec++;
    if (q !== 8'h00 || sout !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL shl9_sat: q=%h sout=%b done=%b, want 00 0 1", q, sout, done);
    end
    cyc();
    do_load(8'h80);
    do_start(3'b010, 4'd10);
    repeat (10) cyc();
    nvec++;
    if (q !== 8'hFF || sout !== 1'b1 || done !== 1'b1) begin
      nerr++;
      $display("FAIL sar10_sat: q=%h sout=%b done=%b, want FF 1 1", q, sout, done);
    end
    cyc();
  endtask

  task automatic test_serial_in();
    do_load(8'h00);
    sin = 1'b1;
    do_start(3'b101, 4'd4);
    repeat (4) cyc();
    nvec++;
    if (q !== 8'h0F || sout !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL sli4: q=%h sout=%b done=%b, want 0F 0 1", q, sout, done);
    end
    cyc();
    do_start(3'b110, 4'd2);
    repeat (2) cyc();
    nvec++;
    if (q !== 8'hC3 || sout !== 1'b1 || done !== 1'b1) begin
      nerr++;
      $display("FAIL sri2: q=%h sout=%b done=%b, want C3 1 1", q, sout, done);
    end
    sin = 1'b0;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_load(8'h5A);
    do_start(3'b111, 4'd2);
    cyc();
    nvec++;
    if (busy !== 1'b1 || q !== 8'h5A || done !== 1'b0) begin
      nerr++;
      $display("FAIL rsv_mid: busy=%b q=%h done=%b, want 1 5A 0", busy, q, done);
    end
    cyc();
    nvec++;
    if (busy !== 1'b0 || q !== 8'h5A || done !== 1'b1) begin
      nerr++;
      $display("FAIL rsv_end: busy=%b q=%h done=%b, want 0 5A 1", busy, q, done);
    end
    do_start(3'b100, 4'd1);
    nvec++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_start: busy=%b done=%b, want 1 0", busy, done);
    end
    cyc();
    nvec++;
    if (q !== 8'h2D || sout !== 1'b0 || done !== 1'b1) begin
      nerr++;
      $display("FAIL ror1: q=%h sout=%b done=%b, want 2D 0 1", q, sout, done);
    end
    cyc();
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst   = 1'b1;
    en    = 1'b1;
    clr   = 1'b0;
    load  = 1'b0;
    d     = 8'h00;
    start = 1'b0;
    op    = 3'b000;
    amt   = 4'd0;
    sin   = 1'b0;
    #2;
    test_reset();
    #10;
    rst = 1'b0;
    cyc();
    test_reset();
    test_rol_one();
    test_sar_shr();
    test_pause();
    test_amt_zero();
    test_clr_abort();
    test_rst_mid_op();
    test_wide_amt();
    test_serial_in();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
